// File: rtl/win_banner_render.sv
// Win banner: maps the pixel stream onto the banner window, addresses the ROM, composites over background, runs hide/blink/hold FSM.
// Latency 2 cycles de/bg_rgb -> rgb_out/de_out, no backpressure; define BANNER_BORDER_EN for a 1-pixel white window border.
module win_banner_render #(
  parameter int IMG_W        = 20,
  parameter int IMG_H        = 15,
  parameter int X0           = 240,
  parameter int Y0           = 180,
  parameter int SCALE_SH     = 3,
  parameter int BLINK_FRAMES = 30,
  parameter int BLINK_PHASES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       de,
  input  logic       frame_start,
  input  logic       win_valid,
  input  logic       win_id,
  input  logic       clear,
  input  logic [2:0] bg_rgb,
  output logic [8:0] rom_addr,
  output logic       rom_sel,
  input  logic [2:0] rom_q,
  output logic [2:0] rgb_out,
  output logic       de_out,
  output logic       banner_busy
);

  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + (IMG_W << SCALE_SH) - 1);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + (IMG_H << SCALE_SH) - 1);
  localparam int          FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int          PW   = (BLINK_PHASES > 1) ? $clog2(BLINK_PHASES) : 1;
  localparam logic [FW-1:0] FR_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(BLINK_PHASES - 1);

  typedef enum logic [1:0] {IDLE, BLINK, HOLD} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          rom_sel_q, rom_sel_d;

  logic [8:0]    rom_addr_q, rom_addr_d;
  logic          in_win_q, in_win_d;
  logic          de_q, de_d;
  logic [2:0]    bg_q, bg_d;
  logic          vis_q, vis_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          de_out_q, de_out_d;
`ifdef BANNER_BORDER_EN
  logic          edge_q, edge_d;
`endif

  logic       visible;
  logic [9:0] h_off, v_off;
  logic [8:0] col, row, addr_full;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    rom_sel_d   = rom_sel_q;
    if (clear) begin
      state_d     = IDLE;
      frame_cnt_d = '0;
      phase_d     = '0;
    end else begin
      case (state_q)
        IDLE: if (win_valid) begin
          rom_sel_d   = win_id;
          frame_cnt_d = '0;
          phase_d     = '0;
          state_d     = BLINK;
        end
        BLINK: if (frame_start) begin
          if (frame_cnt_q == FR_LAST) begin
            frame_cnt_d = '0;
            if (phase_q == PH_LAST) state_d = HOLD;
            else                    phase_d = phase_q + 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        HOLD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Even phases show the banner, so the first blink phase is visible.
  assign visible = (state_q == HOLD) || (state_q == BLINK && !phase_q[0]);

  always_comb begin
    h_off     = hcount - 10'(X0);
    v_off     = vcount - 10'(Y0);
    col       = 9'(h_off >> SCALE_SH);
    row       = 9'(v_off >> SCALE_SH);
    addr_full = col;
    for (int b = 0; b < 9; b++) begin
      if (((IMG_W >> b) & 1) != 0) addr_full = addr_full + (row << b);
    end
    in_win_d   = de && ({1'b0, hcount} >= X_LO) && ({1'b0, hcount} <= X_HI)
                    && ({1'b0, vcount} >= Y_LO) && ({1'b0, vcount} <= Y_HI);
    rom_addr_d = in_win_d ? addr_full : 9'd0;
    de_d       = de;
    bg_d       = bg_rgb;
    vis_d      = visible;
`ifdef BANNER_BORDER_EN
    edge_d     = in_win_d && (({1'b0, hcount} == X_LO) || ({1'b0, hcount} == X_HI)
                           || ({1'b0, vcount} == Y_LO) || ({1'b0, vcount} == Y_HI));
`endif
  end

  always_comb begin
    rgb_d    = 3'd0;
    de_out_d = de_q;
    if (de_q) begin
      rgb_d = bg_q;
      if (vis_q && in_win_q && rom_q != 3'd0) rgb_d = rom_q;
`ifdef BANNER_BORDER_EN
      if (vis_q && edge_q) rgb_d = 3'd7;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      phase_q     <= '0;
      rom_sel_q   <= 1'b0;
      rom_addr_q  <= '0;
      in_win_q    <= 1'b0;
      de_q        <= 1'b0;
      bg_q        <= '0;
      vis_q       <= 1'b0;
      rgb_q       <= '0;
      de_out_q    <= 1'b0;
`ifdef BANNER_BORDER_EN
      edge_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      rom_sel_q   <= rom_sel_d;
      rom_addr_q  <= rom_addr_d;
      in_win_q    <= in_win_d;
      de_q        <= de_d;
      bg_q        <= bg_d;
      vis_q       <= vis_d;
      rgb_q       <= rgb_d;
      de_out_q    <= de_out_d;
`ifdef BANNER_BORDER_EN
      edge_q      <= edge_d;
`endif
    end
  end

  assign rom_addr    = rom_addr_q;
  assign rom_sel     = rom_sel_q;
  assign rgb_out     = rgb_q;
  assign de_out      = de_out_q;
  assign banner_busy = (state_q != IDLE);

endmodule

// File: tb/tb_win_banner_render.sv
// Testbench for win_banner_render: directed and randomized pixel streams against a frame-count reference model.
module tb_win_banner_render;

  localparam int X0 = 240, Y0 = 180, IMG_W = 20, IMG_H = 15, TEX = 8;
  localparam int WIN_W = IMG_W * TEX, WIN_H = IMG_H * TEX;
  localparam int FRAMES = 30, PHASES = 6, BLINK_TOTAL = FRAMES * PHASES;

  logic       clk = 1'b0;
  logic       rst, de, frame_start, win_valid, win_id, clear;
  logic [9:0] hcount, vcount;
  logic [2:0] bg_rgb, rom_q, rgb_out;
  logic [8:0] rom_addr;
  logic       rom_sel, de_out, banner_busy;

  logic       rom_force;
  logic [2:0] rom_force_val;

  int checks = 0;
  int errors = 0;

  // Reference model: frames seen since the win decided blink/hold state.
  logic       m_busy, m_sel;
  int         m_k;
  logic [2:0] pend_rgb;
  logic       pend_de;
  logic [8:0] exp_addr;
  logic [2:0] exp_rgb;
  logic       exp_de, exp_sel, exp_busy;

  win_banner_render dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .de(de),
    .frame_start(frame_start), .win_valid(win_valid), .win_id(win_id), .clear(clear),
    .bg_rgb(bg_rgb), .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_q(rom_q),
    .rgb_out(rgb_out), .de_out(de_out), .banner_busy(banner_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_fn(input logic sel, input logic [8:0] a);
    int v;
    v = int'(a) * 5 + (int'(a) >> 4) + (sel ? 3 : 0);
    return 3'(v);
  endfunction

  assign rom_q = rom_force ? rom_force_val : rom_fn(rom_sel, rom_addr);

  task automatic model_reset();
    m_busy = 1'b0; m_sel = 1'b0; m_k = 0; pend_rgb = 3'd0; pend_de = 1'b0;
  endtask

  task automatic tick();
    logic vis, inw;
    logic [8:0] a;
    logic [2:0] rv, cur;
    int col, row;
    vis = m_busy && (m_k >= BLINK_TOTAL || ((m_k / FRAMES) % 2) == 0);
    inw = de && int'(hcount) >= X0 && int'(hcount) < X0 + WIN_W
             && int'(vcount) >= Y0 && int'(vcount) < Y0 + WIN_H;
    a = 9'd0;
    if (inw) begin
      col = (int'(hcount) - X0) / TEX;
      row = (int'(vcount) - Y0) / TEX;
      a = 9'(row * IMG_W + col);
    end
    if (clear) begin
      m_busy = 1'b0; m_k = 0;
    end else if (!m_busy && win_valid) begin
      m_busy = 1'b1; m_k = 0; m_sel = win_id;
    end else if (m_busy && frame_start && m_k < BLINK_TOTAL) begin
      m_k++;
    end
    rv  = rom_force ? rom_force_val : rom_fn(m_sel, a);
    cur = 3'd0;
    if (de) begin
      cur = bg_rgb;
      if (vis && inw && rv != 3'd0) cur = rv;
`ifdef BANNER_BORDER_EN
      if (vis && inw && (int'(hcount) == X0 || int'(hcount) == X0 + WIN_W - 1 ||
                         int'(vcount) == Y0 || int'(vcount) == Y0 + WIN_H - 1)) cur = 3'd7;
`endif
    end
    exp_addr = a; exp_sel = m_sel; exp_busy = m_busy;
    exp_rgb = pend_rgb; exp_de = pend_de;
    pend_rgb = cur; pend_de = de;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; de = 1'b1; hcount = 10'(X0 + 8); vcount = 10'(Y0 + 8); bg_rgb = 3'd5;
    frame_start = 1'b1; win_valid = 1'b1; win_id = 1'b1; clear = 1'b0;
    rom_force = 1'b0; rom_force_val = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rom_addr !== 9'd0)    begin errors++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    checks++; if (rom_sel !== 1'b0)     begin errors++; $display("FAIL reset_rom_sel: got %0d expected 0", rom_sel); end
    checks++; if (rgb_out !== 3'd0)     begin errors++; $display("FAIL reset_rgb_out: got %0d expected 0", rgb_out); end
    checks++; if (de_out !== 1'b0)      begin errors++; $display("FAIL reset_de_out: got %0d expected 0", de_out); end
    checks++; if (banner_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", banner_busy); end
    rst = 1'b0; frame_start = 1'b0; win_valid = 1'b0; win_id = 1'b0; de = 1'b0;
    model_reset();
  endtask

  task automatic test_background();
    de = 1'b1; vcount = 10'd0; bg_rgb = 3'd3;
    for (int i = 0; i < 642; i++) begin
      if (i == 640) de = 1'b0;
      hcount = 10'(i % 640);
      tick();
      checks++; if (rgb_out !== exp_rgb)      begin errors++; $display("FAIL bg_rgb i=%0d: got %0d expected %0d", i, rgb_out, exp_rgb); end
      checks++; if (de_out !== exp_de)        begin errors++; $display("FAIL bg_de i=%0d: got %0d expected %0d", i, de_out, exp_de); end
      checks++; if (rom_addr !== exp_addr)    begin errors++; $display("FAIL bg_addr i=%0d: got %0d expected %0d", i, rom_addr, exp_addr); end
      checks++; if (banner_busy !== exp_busy) begin errors++; $display("FAIL bg_busy i=%0d: got %0d expected %0d", i, banner_busy, exp_busy); end
    end
  endtask

  task automatic test_directed();
    de = 1'b0; win_valid = 1'b1; win_id = 1'b1; tick(); win_valid = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    rom_force = 1'b1; rom_force_val = 3'd5;
    de = 1'b1; hcount = 10'(X0 + 48); vcount = 10'(Y0); bg_rgb = 3'd2; tick();
    checks++; if (rom_addr !== 9'd6)    begin errors++; $display("FAIL dir_addr6: got %0d expected 6", rom_addr); end
    checks++; if (rom_sel !== 1'b1)     begin errors++; $display("FAIL dir_sel1: got %0d expected 1", rom_sel); end
    checks++; if (banner_busy !== 1'b1) begin errors++; $display("FAIL dir_busy: got %0d expected 1", banner_busy); end
    hcount = 10'(X0 + 8*19 + 7); vcount = 10'(Y0 + 8*14 + 7); bg_rgb = 3'd1; tick();
    checks++; if (rgb_out !== 3'd5)     begin errors++; $display("FAIL dir_rgb_rom: got %0d expected 5", rgb_out); end
    checks++; if (de_out !== 1'b1)      begin errors++; $display("FAIL dir_de_out: got %0d expected 1", de_out); end
    checks++; if (rom_addr !== 9'd299)  begin errors++; $display("FAIL dir_addr299: got %0d expected 299", rom_addr); end
    hcount = 10'(X0 + 160); vcount = 10'(Y0 + 8); bg_rgb = 3'd4; tick();
    checks++; if (rgb_out !== 3'd5)     begin errors++; $display("FAIL dir_rgb_last_texel: got %0d expected 5", rgb_out); end
    checks++; if (rom_addr !== 9'd0)    begin errors++; $display("FAIL dir_addr_outside: got %0d expected 0", rom_addr); end
    rom_force_val = 3'd0;
    hcount = 10'(X0 + 20); vcount = 10'(Y0 + 20); bg_rgb = 3'd6; tick();
    checks++; if (rgb_out !== 3'd4)     begin errors++; $display("FAIL dir_rgb_outside: got %0d expected 4", rgb_out); end
    checks++; if (rom_addr !== 9'd42)   begin errors++; $display("FAIL dir_addr42: got %0d expected 42", rom_addr); end
    de = 1'b0; tick();
    checks++; if (rgb_out !== 3'd6)     begin errors++; $display("FAIL dir_transparent: got %0d expected 6", rgb_out); end
    rom_force_val = 3'd5;
    de = 1'b1; hcount = 10'(X0); vcount = 10'(Y0 + 5); bg_rgb = 3'd1; tick();
    de = 1'b0; tick();
`ifdef BANNER_BORDER_EN
    checks++; if (rgb_out !== 3'd7)     begin errors++; $display("FAIL dir_border: got %0d expected 7", rgb_out); end
`else
    checks++; if (rgb_out !== 3'd5)     begin errors++; $display("FAIL dir_edge_no_border: got %0d expected 5", rgb_out); end
`endif
    rom_force = 1'b0;
    tick(); tick();
  endtask

  task automatic test_blink_random();
    clear = 1'b1; tick(); clear = 1'b0;
    win_valid = 1'b1; win_id = 1'($urandom_range(0, 1)); tick(); win_valid = 1'b0;
    for (int f = 0; f < 200; f++) begin
      for (int p = 0; p < 11; p++) begin
        frame_start = (p == 0);
        de          = (p == 0) ? 1'b0 : ($urandom_range(0, 7) != 0);
        hcount      = 10'($urandom_range(X0 - 4, X0 + WIN_W + 3));
        vcount      = 10'($urandom_range(Y0 - 4, Y0 + WIN_H + 3));
        bg_rgb      = 3'($urandom_range(0, 7));
        win_valid   = ($urandom_range(0, 15) == 0);
        win_id      = 1'($urandom_range(0, 1));
        tick();
        checks++; if (rgb_out !== exp_rgb)      begin errors++; $display("FAIL blink_rgb f=%0d p=%0d: got %0d expected %0d", f, p, rgb_out, exp_rgb); end
        checks++; if (de_out !== exp_de)        begin errors++; $display("FAIL blink_de f=%0d p=%0d: got %0d expected %0d", f, p, de_out, exp_de); end
        checks++; if (rom_addr !== exp_addr)    begin errors++; $display("FAIL blink_addr f=%0d p=%0d: got %0d expected %0d", f, p, rom_addr, exp_addr); end
        checks++; if (rom_sel !== exp_sel)      begin errors++; $display("FAIL blink_sel f=%0d p=%0d: got %0d expected %0d", f, p, rom_sel, exp_sel); end
        checks++; if (banner_busy !== exp_busy) begin errors++; $display("FAIL blink_busy f=%0d p=%0d: got %0d expected %0d", f, p, banner_busy, exp_busy); end
      end
    end
    frame_start = 1'b0; win_valid = 1'b0; de = 1'b0;
  endtask

  task automatic test_clear_and_win();
    logic old_sel;
    old_sel = m_sel;
    clear = 1'b1; win_valid = 1'b1; win_id = ~old_sel; tick();
    clear = 1'b0; win_valid = 1'b0;
    checks++; if (banner_busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %0d expected 0", banner_busy); end
    checks++; if (rom_sel !== old_sel)  begin errors++; $display("FAIL clr_sel_kept: got %0d expected %0d", rom_sel, old_sel); end
    rom_force = 1'b1; rom_force_val = 3'd5;
    de = 1'b1; hcount = 10'(X0 + 64); vcount = 10'(Y0 + 64); bg_rgb = 3'd2; tick();
    de = 1'b0; tick();
    checks++; if (rgb_out !== 3'd2)     begin errors++; $display("FAIL clr_hidden: got %0d expected 2", rgb_out); end
    rom_force = 1'b0;
    repeat (3) tick();
    win_valid = 1'b1; win_id = 1'b0; tick(); win_valid = 1'b0;
    checks++; if (rom_sel !== 1'b0)     begin errors++; $display("FAIL win2_sel: got %0d expected 0", rom_sel); end
    checks++; if (banner_busy !== 1'b1) begin errors++; $display("FAIL win2_busy: got %0d expected 1", banner_busy); end
  endtask

  task automatic test_rst_mid_blink();
    for (int f = 0; f < 3; f++) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0;
    end
    de = 1'b1; hcount = 10'(X0 + 9); vcount = 10'(Y0 + 9); bg_rgb = 3'd3; tick();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (rgb_out !== 3'd0)     begin errors++; $display("FAIL rst_mid_rgb: got %0d expected 0", rgb_out); end
    checks++; if (de_out !== 1'b0)      begin errors++; $display("FAIL rst_mid_de: got %0d expected 0", de_out); end
    checks++; if (rom_addr !== 9'd0)    begin errors++; $display("FAIL rst_mid_addr: got %0d expected 0", rom_addr); end
    checks++; if (banner_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0d expected 0", banner_busy); end
    rst = 1'b0; de = 1'b0;
    model_reset();
    tick();
    checks++; if (banner_busy !== exp_busy) begin errors++; $display("FAIL rst_after_busy: got %0d expected %0d", banner_busy, exp_busy); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_background();
    test_directed();
    test_blink_random();
    test_clear_and_win();
    test_rst_mid_blink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
